// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags, sticky
// error flags, synchronous flush and a selectable first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             flush,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             DEPTH     = 2 ** ASIZE;
    localparam logic [ASIZE:0] DEPTH_CNT = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] AF_CNT    = (ASIZE + 1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_CNT    = (ASIZE + 1)'(AE_LEVEL);

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic [ASIZE:0]   r_count;
    logic [ASIZE:0]   w_count_nxt;
    logic             r_wfull;
    logic             r_rempty;
    logic             r_afull;
    logic             r_aempty;
    logic             r_ovf;
    logic             r_udf;
    logic             w_wr_en;
    logic             w_rd_en;

    // Full blocks writes even when a read is accepted in the same cycle.
    assign w_wr_en = winc && !r_wfull && !flush && !rst;
    assign w_rd_en = rinc && !r_rempty && !flush && !rst;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_en && !w_rd_en) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr_en && w_rd_en) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[ASIZE-1:0]] <= wdata;
        end
    end

    // Flags come from the next count so they line up with count itself.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_wfull  <= 1'b0;
            r_rempty <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count  <= w_count_nxt;
            r_wfull  <= (w_count_nxt == DEPTH_CNT);
            r_rempty <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= AF_CNT);
            r_aempty <= (w_count_nxt <= AE_CNT);
            if (winc && r_wfull) begin
                r_ovf <= 1'b1;
            end
            if (rinc && r_rempty) begin
                r_udf <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata  = r_rempty ? '0 : r_mem[r_rptr[ASIZE-1:0]];
            assign rvalid = !r_rempty;
        end else begin : g_std
            logic [DSIZE-1:0] r_rdata;
            logic             r_rvalid;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_en;
                    if (w_rd_en) begin
                        r_rdata <= r_mem[r_rptr[ASIZE-1:0]];
                    end
                end
            end

            assign rdata  = r_rdata;
            assign rvalid = r_rvalid;
        end
    endgenerate

    assign wfull         = r_wfull;
    assign rempty        = r_rempty;
    assign walmost_full  = r_afull;
    assign ralmost_empty = r_aempty;
    assign count         = r_count;
    assign overflow      = r_ovf;
    assign underflow     = r_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard and an FWFT instance share one stimulus
// stream and are compared every cycle against a queue-based reference.
module tb_sync_fifo_param;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst, winc, rinc, flush;
    logic [7:0] wdata;

    logic [7:0] rdata0, rdata1;
    logic       rvalid0, rvalid1, wfull0, wfull1, rempty0, rempty1;
    logic       afull0, afull1, aempty0, aempty1, ovf0, ovf1, udf0, udf1;
    logic [4:0] count0, count1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .flush(flush),
        .rdata(rdata0), .rvalid(rvalid0), .wfull(wfull0), .rempty(rempty0),
        .walmost_full(afull0), .ralmost_empty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .flush(flush),
        .rdata(rdata1), .rvalid(rvalid1), .wfull(wfull1), .rempty(rempty1),
        .walmost_full(afull1), .ralmost_empty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: contents as a queue, errors as plain booleans.
    logic [7:0] mq[$];
    logic       m_ovf, m_udf, m_rv0, m_full, m_empty;
    logic [7:0] m_rd0;
    int         n;

    always @(posedge clk) begin
        if (rst || flush) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rd0 = 8'h00;
            m_rv0 = 1'b0;
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            m_rv0   = 1'b0;
            if (winc && m_full)  m_ovf = 1'b1;
            if (rinc && m_empty) m_udf = 1'b1;
            if (rinc && !m_empty) begin
                m_rd0 = mq.pop_front();
                m_rv0 = 1'b1;
            end
            if (winc && !m_full) mq.push_back(wdata);
        end
        #1;
        n = mq.size();
        check("count0",  32'(count0),  32'(n));
        check("count1",  32'(count1),  32'(n));
        check("rempty0", 32'(rempty0), 32'(n == 0));
        check("rempty1", 32'(rempty1), 32'(n == 0));
        check("wfull0",  32'(wfull0),  32'(n == DEPTH));
        check("wfull1",  32'(wfull1),  32'(n == DEPTH));
        check("afull0",  32'(afull0),  32'(n >= AF));
        check("afull1",  32'(afull1),  32'(n >= AF));
        check("aempty0", 32'(aempty0), 32'(n <= AE));
        check("aempty1", 32'(aempty1), 32'(n <= AE));
        check("ovf0",    32'(ovf0),    32'(m_ovf));
        check("ovf1",    32'(ovf1),    32'(m_ovf));
        check("udf0",    32'(udf0),    32'(m_udf));
        check("udf1",    32'(udf1),    32'(m_udf));
        check("rdata0",  32'(rdata0),  32'(m_rd0));
        check("rvalid0", 32'(rvalid0), 32'(m_rv0));
        check("rdata1",  32'(rdata1),  32'((n == 0) ? 8'h00 : mq[0]));
        check("rvalid1", 32'(rvalid1), 32'(n != 0));
    end

    task automatic step(input logic r, input logic w, input logic [7:0] d,
                        input logic rd, input logic f);
        rst   = r;
        winc  = w;
        wdata = d;
        rinc  = rd;
        flush = f;
        @(negedge clk);
    endtask

    int pulses;
    int wprob;

    initial begin
        // Reset with both requests high
        step(1, 1, 8'hAA, 1, 0);
        step(1, 1, 8'hAB, 1, 0);
        check("rst_count",  32'(count0),  32'd0);
        check("rst_rempty", 32'(rempty0), 32'd1);
        check("rst_wfull",  32'(wfull0),  32'd0);
        check("rst_rdata",  32'(rdata0),  32'd0);
        check("rst_ovf",    32'(ovf0),    32'd0);

        // Fill
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(8'h12 + i), 0, 0);
            if (i == 10) check("fill_afull_11", 32'(afull0), 32'd0);
            if (i == 11) check("fill_afull_12", 32'(afull0), 32'd1);
        end
        check("fill_wfull", 32'(wfull0), 32'd1);
        check("fill_count", 32'(count0), 32'd16);
        step(0, 1, 8'hFF, 0, 0);
        check("fill_ovf",   32'(ovf0),   32'd1);
        check("fill_count17", 32'(count0), 32'd16);

        // Drain
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 8'h00, 1, 0);
            if (rvalid0) pulses++;
            if (i < 16) check("drain_rdata", 32'(rdata0), 32'(8'h12 + i));
            if (i == 12) check("drain_aempty3", 32'(aempty0), 32'd0);
            if (i == 13) check("drain_aempty2", 32'(aempty0), 32'd1);
            if (i == 14) check("drain_rempty1", 32'(rempty0), 32'd0);
            if (i == 15) check("drain_rempty0", 32'(rempty0), 32'd1);
        end
        check("drain_pulses", 32'(pulses),  32'd16);
        check("drain_udf",    32'(udf0),    32'd1);
        check("drain_hold",   32'(rdata0),  32'h21);
        check("drain_rvalid", 32'(rvalid0), 32'd0);

        // Concurrent read/write across pointer wraps
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 8'(i), 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 8'(5 + i), 1, 0);
        check("conc_count", 32'(count0), 32'd5);
        check("conc_rdata", 32'(rdata0), 32'd39);
        check("conc_ovf",   32'(ovf0),   32'd0);

        // Flush at count 9 with overflow set
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 17; i++) step(0, 1, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, 0);
        check("pre_flush_count", 32'(count0), 32'd9);
        check("pre_flush_ovf",   32'(ovf0),   32'd1);
        step(0, 1, 8'h77, 0, 1);
        check("flush_count",  32'(count0),  32'd0);
        check("flush_rempty", 32'(rempty0), 32'd1);
        check("flush_ovf",    32'(ovf0),    32'd0);
        check("flush_rdata",  32'(rdata0),  32'd0);
        step(0, 1, 8'hA1, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        check("post_flush_rdata", 32'(rdata0), 32'hA1);

        // FWFT behaviour from empty
        step(0, 1, 8'h55, 0, 0);
        check("fwft_rempty", 32'(rempty1), 32'd0);
        check("fwft_rvalid", 32'(rvalid1), 32'd1);
        check("fwft_rdata",  32'(rdata1),  32'h55);
        step(0, 1, 8'h66, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        check("fwft_pop_rdata", 32'(rdata1), 32'h66);
        step(0, 0, 8'h00, 1, 0);
        check("fwft_empty",  32'(rempty1), 32'd1);
        check("fwft_rvalid0", 32'(rvalid1), 32'd0);

        // Random traffic with phases biased towards full and towards empty
        for (int p = 0; p < 10; p++) begin
            wprob = (p % 2 == 0) ? 75 : 25;
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < wprob,
                     8'($urandom),
                     $urandom_range(0, 99) < (100 - wprob),
                     $urandom_range(0, 127) == 0);
            end
        end

        step(0, 0, 8'h00, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO: width, depth and flag thresholds are configurable.
- Adds an occupancy count, almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Used where producer and consumer share one clock, as a rate-smoothing buffer between pipeline stages.

Parameters:
DSIZE, 8, data width in bits
ASIZE, 4, address width; DEPTH = 2**ASIZE entries
AF_LEVEL, 12, walmost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, ralmost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
Legal range: 0 <= AE_LEVEL < AF_LEVEL <= DEPTH.

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
wdata  input  DSIZE  write data
winc  input  1  write request
rinc  input  1  read request (pop in FWFT mode)
flush  input  1  synchronous clear of contents and error flags
rdata  output  DSIZE  read data
rvalid  output  1  rdata valid
wfull  output  1  count == DEPTH
rempty  output  1  count == 0
walmost_full  output  1  count >= AF_LEVEL
ralmost_empty  output  1  count <= AE_LEVEL
count  output  ASIZE+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset and clocking (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: rdata=0, rvalid=0, count=0, rempty=1, wfull=0, walmost_full=0, ralmost_empty=1, overflow=0, underflow=0. Write and read pointers = 0.
- Priority each cycle: rst > flush > winc/rinc.
- Storage: DEPTH x DSIZE register array. Write and read pointers are ASIZE+1 bits and wrap modulo 2*DEPTH. Memory index = pointer[ASIZE-1:0].
- Write accepted iff winc && !wfull. Data is stored at the write pointer; the write pointer increments.
- Read accepted iff rinc && !rempty. The read pointer increments.
- No pass-through when full: winc while wfull is rejected even if rinc is accepted in the same cycle.
- Count update, registered:
  - +1 on a write alone
  - -1 on a read alone
  - unchanged when both are accepted in the same cycle
- All flags are registered, derived from the next-count value, so they are valid in the cycle after the event. Zero-cycle flag latency relative to count.
- overflow sets on winc && wfull. underflow sets on rinc && rempty. Both hold until rst or flush.
- FWFT=0:
  - On an accepted read, rdata is loaded from mem[rptr] at that edge and rvalid=1 for exactly one cycle. Read latency is 1 cycle.
  - Otherwise rdata holds its last value and rvalid=0.
  - A rejected read leaves rdata unchanged.
- FWFT=1:
  - rdata = mem[rptr] whenever rempty=0; rvalid = !rempty.
  - rinc pops the head; the next entry is presented in the following cycle.
  - Write to an empty FIFO: rempty=0 and rdata shows the written word in the cycle after the write.
- flush:
  - Pointers, count, overflow and underflow go to 0. rempty=1, ralmost_empty=1, others 0 next cycle.
  - rdata=0, rvalid=0.
  - Any winc/rinc in the flush cycle is ignored.
- Memory contents are not cleared by rst or flush.

Test Plan:
- Reset: drive rst=1 for 2 cycles with winc=rinc=1 -> rempty=1, wfull=0, count=0, rdata=0, no flags set; all outputs stable through reset.
- Fill: FWFT=0, write 16 words 0x12..0x21, rinc=0:
  - walmost_full rises the cycle after the 12th write.
  - wfull=1 and count=16 after the 16th write.
  - A 17th write of 0xFF is rejected: overflow=1, count stays 16.
- Drain: from full, rinc=1 for 17 cycles:
  - rdata = 0x12..0x21 in order, each 1 cycle after its rinc, with rvalid pulsed 16 times.
  - ralmost_empty rises at count=2; rempty rises after the 16th read.
  - The 17th rinc sets underflow=1 and rdata holds 0x21.
- Concurrent and wrap: preload 5 words, then winc=rinc=1 for 40 cycles with an incrementing pattern -> count stays 5, no flags change, read order matches write order across multiple pointer wraps.
- Flush: at count=9 with overflow=1, assert flush with winc=1 and wdata=0x77 -> next cycle count=0, rempty=1, overflow=0; 0x77 is not stored, and a later read sees only newly written data.
- FWFT=1: write 0x55 into an empty FIFO:
  - Next cycle rempty=0, rvalid=1, rdata=0x55 with no rinc.
  - Write 0x66, then pulse rinc -> rdata=0x66 the next cycle.
  - A second rinc makes rempty=1, rvalid=0.
